i2s_sample_framer: RTL and testbench

Downstream stage of the I2S receiver. Detects each completed stereo pair, reduces it to one signed mono (or single-channel) sample and buffers it in a small FIFO. Presents the sample stream over a valid/ready interface with frame markers every FRAME_LEN samples, which the FFT/visualizer path consumes.

---
 rtl/i2s_sample_framer_if.sv | 26 ++
 rtl/i2s_sample_framer.sv | 159 +++++++++++++++
 tb/tb_i2s_sample_framer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_sample_framer_if.sv
// Sample stream from the I2S framer to the FFT/visualizer path.
interface i2s_sample_framer_if #(
    parameter int unsigned SAMPLE_WIDTH = 24
) ();
    logic                    out_valid;
    logic                    out_ready;
    logic [SAMPLE_WIDTH-1:0] out_data;
    logic                    out_first;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/i2s_sample_framer.sv
// Turns each completed I2S stereo pair into one signed sample, buffers it in a
// show-ahead FIFO and streams it out with frame-start/frame-end markers.
module i2s_sample_framer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FRAME_LEN    = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sck,
    input  logic                                 ws,
    input  logic [DATA_WIDTH-1:0]                data_left,
    input  logic [DATA_WIDTH-1:0]                data_right,
    input  logic [1:0]                           mode,
    input  logic                                 clear_ovf,
    output logic                                 overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
    i2s_sample_framer_if.master                  stream
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned WORD_W = SAMPLE_WIDTH + 2;

    // Front end: sck edge detect, ws history, pair strobe, capture
    logic                    sckd_q, sckdd_q, wsd_q, wsdd_q;
    logic                    pair_stb_q, cap_valid_q;
    logic [SAMPLE_WIDTH-1:0] cap_l_q, cap_r_q;
    logic [1:0]              cap_mode_q;
    logic                    sck_rise;

    assign sck_rise = sckd_q & ~sckdd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sckd_q      <= 1'b0;
            sckdd_q     <= 1'b0;
            wsd_q       <= 1'b0;
            wsdd_q      <= 1'b0;
            pair_stb_q  <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_l_q     <= '0;
            cap_r_q     <= '0;
            cap_mode_q  <= 2'd0;
        end else begin
            sckd_q      <= sck;
            sckdd_q     <= sckd_q;
            if (sck_rise) begin
                wsd_q  <= ws;
                wsdd_q <= wsd_q;
            end
            pair_stb_q  <= sck_rise & ~wsd_q & wsdd_q;
            cap_valid_q <= pair_stb_q;
            if (pair_stb_q) begin
                cap_l_q    <= data_left[DATA_WIDTH-1 -: SAMPLE_WIDTH];
                cap_r_q    <= data_right[DATA_WIDTH-1 -: SAMPLE_WIDTH];
                cap_mode_q <= mode;
            end
        end
    end

    generate
        if (DATA_WIDTH > SAMPLE_WIDTH) begin : g_unused
            logic unused_low_bits;
            assign unused_low_bits = ^{data_left[DATA_WIDTH-SAMPLE_WIDTH-1:0],
                                       data_right[DATA_WIDTH-SAMPLE_WIDTH-1:0]};
        end
    endgenerate

    // Reduce: floor average of the sign-extended pair cannot overflow
    logic [SAMPLE_WIDTH:0]   sum;
    logic [SAMPLE_WIDTH-1:0] result;
    logic [IDX_W-1:0]        idx_q;
    logic [WORD_W-1:0]       wr_word;

    always_comb begin
        sum = {cap_l_q[SAMPLE_WIDTH-1], cap_l_q} + {cap_r_q[SAMPLE_WIDTH-1], cap_r_q};
        case (cap_mode_q)
            2'd0:    result = sum[SAMPLE_WIDTH:1];
            2'd2:    result = cap_r_q;
            default: result = cap_l_q;
        endcase
        wr_word = {idx_q == '0, idx_q == IDX_W'(FRAME_LEN - 1), result};
    end

    // FIFO: level counts the head register plus the memory entries
    logic [WORD_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [LVL_W-1:0]        level_q;
    logic                    ovf_q;
    logic                    head_valid_q, head_first_q, head_last_q;
    logic [SAMPLE_WIDTH-1:0] head_data_q;
    logic                    rd, full, wr_acc, drop, mem_empty, head_load, bypass, mem_wr;

    always_comb begin
        rd        = head_valid_q & stream.out_ready;
        full      = level_q == LVL_W'(FIFO_DEPTH);
        wr_acc    = cap_valid_q & (~full | rd);
        drop      = cap_valid_q & full & ~rd;
        // The head is refilled whenever the memory holds data, so equal pointers mean empty
        mem_empty = wptr_q == rptr_q;
        head_load = ~head_valid_q | rd;
        bypass    = head_load & mem_empty & wr_acc;
        mem_wr    = wr_acc & ~bypass;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wptr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            ovf_q        <= 1'b0;
            idx_q        <= '0;
            head_valid_q <= 1'b0;
            head_first_q <= 1'b0;
            head_last_q  <= 1'b0;
            head_data_q  <= '0;
        end else begin
            level_q <= level_q + LVL_W'(wr_acc) - LVL_W'(rd);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
            if (wr_acc) begin
                idx_q <= idx_q + 1'b1;
            end
            if (mem_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (head_load) begin
                if (!mem_empty) begin
                    {head_first_q, head_last_q, head_data_q} <= mem[rptr_q];
                    head_valid_q <= 1'b1;
                    rptr_q       <= rptr_q + 1'b1;
                end else if (wr_acc) begin
                    {head_first_q, head_last_q, head_data_q} <= wr_word;
                    head_valid_q <= 1'b1;
                end else begin
                    head_valid_q <= 1'b0;
                end
            end
        end
    end

    assign stream.out_valid = head_valid_q;
    assign stream.out_data  = head_data_q;
    assign stream.out_first = head_first_q;
    assign stream.out_last  = head_last_q;
    assign overflow         = ovf_q;
    assign level            = level_q;
endmodule

// File: tb/tb_i2s_sample_framer.sv
// Randomized bench for i2s_sample_framer against a queue-based sample model.
module tb_i2s_sample_framer;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 24;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned FLEN  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sck = 1'b0;
    logic          ws = 1'b0;
    logic          clear_ovf = 1'b0;
    logic [DW-1:0] data_left = '0;
    logic [DW-1:0] data_right = '0;
    logic [1:0]    mode = 2'd0;
    logic          overflow;
    logic [4:0]    level;

    i2s_sample_framer_if #(.SAMPLE_WIDTH(SW)) stream ();

    i2s_sample_framer #(
        .DATA_WIDTH  (DW),
        .SAMPLE_WIDTH(SW),
        .FIFO_DEPTH  (DEPTH),
        .FRAME_LEN   (FLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .ws        (ws),
        .data_left (data_left),
        .data_right(data_right),
        .mode      (mode),
        .clear_ovf (clear_ovf),
        .overflow  (overflow),
        .level     (level),
        .stream    (stream)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a sample per pair, tagged by its position among accepted samples
    typedef struct packed {
        logic [SW-1:0] data;
        logic          first;
        logic          last;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned m_idx = 0;
    logic        m_ovf = 1'b0;
    int          n_pushed = 0;

    function automatic logic [SW-1:0] model_reduce(input logic [31:0] l, input logic [31:0] r,
                                                   input logic [1:0] m);
        int sl, sr, s;
        sl = $signed(l) >>> (DW - SW);
        sr = $signed(r) >>> (DW - SW);
        case (m)
            2'd0:    s = (sl + sr) >>> 1;
            2'd2:    s = sr;
            default: s = sl;
        endcase
        return s[SW-1:0];
    endfunction

    task automatic model_write(input logic [SW-1:0] d);
        exp_t e;
        if (exp_q.size() >= DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            e.data  = d;
            e.first = (m_idx == 0);
            e.last  = (m_idx == FLEN - 1);
            exp_q.push_back(e);
            n_pushed++;
            m_idx = (m_idx + 1) % FLEN;
        end
    endtask

    // Consumer ready: fixed or random, changed just after the edge
    bit ready_rand  = 1'b0;
    bit ready_fixed = 1'b1;
    always @(posedge clk) begin
        #1;
        stream.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Monitor: compare transfers with the model, check holds under backpressure
    int            n_xfer = 0;
    int            n_first = 0;
    int            n_last = 0;
    int unsigned   last_xfer_cyc = 0;
    logic [SW-1:0] last_data = '0;
    logic          last_first = 1'b0;
    bit            hold_v = 1'b0;
    logic [SW-1:0] held_data;
    logic          held_first, held_last;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && stream.out_valid) begin
            if (hold_v) begin
                check_eq("hold_data", 32'(stream.out_data), 32'(held_data));
                check_eq("hold_first", 32'(stream.out_first), 32'(held_first));
                check_eq("hold_last", 32'(stream.out_last), 32'(held_last));
            end
            if (stream.out_ready) begin
                n_xfer++;
                last_xfer_cyc = cyc;
                last_data     = stream.out_data;
                last_first    = stream.out_first;
                if (stream.out_first) n_first++;
                if (stream.out_last) n_last++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_sample", 32'(n_xfer), 32'(n_pushed));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("data", 32'(stream.out_data), 32'(e.data));
                    check_eq("first", 32'(stream.out_first), 32'(e.first));
                    check_eq("last", 32'(stream.out_last), 32'(e.last));
                end
                hold_v = 1'b0;
            end else begin
                hold_v     = 1'b1;
                held_data  = stream.out_data;
                held_first = stream.out_first;
                held_last  = stream.out_last;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    int unsigned stb_cyc = 0;

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(stream.out_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(stream.out_data), 32'd0);
        check_eq({tag, "_first"}, 32'(stream.out_first), 32'd0);
        check_eq({tag, "_last"}, 32'(stream.out_last), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_level"}, 32'(level), 32'd0);
    endtask

    // One I2S frame: 4 sck periods with ws=1, then 4 with ws=0; the second rise of the
    // ws=0 half is the one that produces the pair strobe.
    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input bit rst_mid);
        data_left  = l;
        data_right = r;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sck = 1'b0;
            ws  = (i < 4);
            repeat (2) @(negedge clk);
            sck = 1'b1;
            if (i == 5) begin
                stb_cyc = cyc;
                if (rst_mid) begin
                    repeat (3) @(negedge clk);
                    rst = 1'b1;
                    #1;
                    check_all_zero("rst_mid");
                    exp_q.delete();
                    m_idx = 0;
                    m_ovf = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    model_write(model_reduce(l, r, mode));
                end
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 4000 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_idx = 0;
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] dl[7];
    logic [31:0] dr[7];
    logic [1:0]  dm[7];
    logic [31:0] dexp[7];

    initial begin
        dl[0] = 32'h7FFFFF00; dr[0] = 32'h7FFFFF00; dm[0] = 2'd0; dexp[0] = 32'h7FFFFF;
        dl[1] = 32'h80000000; dr[1] = 32'h80000000; dm[1] = 2'd0; dexp[1] = 32'h800000;
        dl[2] = 32'hFFFFFF00; dr[2] = 32'h00000000; dm[2] = 2'd0; dexp[2] = 32'hFFFFFF;
        dl[3] = 32'h00000100; dr[3] = 32'h00000000; dm[3] = 2'd0; dexp[3] = 32'h000000;
        dl[4] = 32'h12345600; dr[4] = 32'hABCDEF00; dm[4] = 2'd1; dexp[4] = 32'h123456;
        dl[5] = 32'h12345600; dr[5] = 32'hABCDEF00; dm[5] = 2'd2; dexp[5] = 32'hABCDEF;
        dl[6] = 32'h12345600; dr[6] = 32'hABCDEF00; dm[6] = 2'd3; dexp[6] = 32'h123456;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed reductions; the first also measures strobe-to-transfer latency
        for (int t = 0; t < 7; t++) begin
            int base;
            base = n_xfer;
            mode = dm[t];
            send_pair(dl[t], dr[t], 1'b0);
            for (int k = 0; k < 200 && n_xfer == base; k++) @(negedge clk);
            check_eq($sformatf("directed_%0d", t), 32'(last_data), dexp[t]);
            // Transfer is 4 clk after the driven sck rise: 2 sync stages, then S+2
            if (t == 0) check_eq("latency", last_xfer_cyc - stb_cyc, 32'd4);
        end
        wait_drain("drain_directed");

        // Frame markers over 9 samples
        do_reset();
        n_first = 0;
        n_last  = 0;
        for (int t = 0; t < 9; t++) begin
            mode = 2'($urandom_range(0, 3));
            send_pair($urandom, $urandom, 1'b0);
        end
        wait_drain("drain_frames");
        check_eq("first_count", 32'(n_first), 32'd3);
        check_eq("last_count", 32'(n_last), 32'd2);

        // Overflow with the consumer stalled
        do_reset();
        ready_fixed = 1'b0;
        for (int t = 0; t < 18; t++) begin
            mode = 2'($urandom_range(0, 3));
            send_pair($urandom, $urandom, 1'b0);
        end
        repeat (6) @(negedge clk);
        check_eq("ovf_level", 32'(level), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'(m_ovf));
        check_eq("ovf_flag_set", 32'(overflow), 32'd1);
        begin
            int base;
            base = n_xfer;
            ready_fixed = 1'b1;
            wait_drain("drain_ovf");
            check_eq("ovf_drained_count", 32'(n_xfer - base), 32'd16);
            check_eq("ovf_level_empty", 32'(level), 32'd0);
            check_eq("ovf_sticky", 32'(overflow), 32'd1);
            base = n_xfer;
            send_pair($urandom, $urandom, 1'b0);
            for (int k = 0; k < 200 && n_xfer == base; k++) @(negedge clk);
            check_eq("post_ovf_first", 32'(last_first), 32'((16 % FLEN) == 0));
        end
        @(negedge clk);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        m_ovf = 1'b0;
        #1;
        check_eq("ovf_cleared", 32'(overflow), 32'(m_ovf));

        // Random data, modes and backpressure
        ready_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            mode = 2'($urandom_range(0, 3));
            send_pair($urandom, $urandom, 1'b0);
        end
        ready_rand = 1'b0;
        wait_drain("drain_random");
        check_eq("random_no_ovf", 32'(overflow), 32'(m_ovf));

        // Reset between strobe and write
        send_pair($urandom, $urandom, 1'b1);
        begin
            int base;
            base = n_xfer;
            mode = 2'd1;
            send_pair(32'h0ABCDE00, $urandom, 1'b0);
            for (int k = 0; k < 200 && n_xfer == base; k++) @(negedge clk);
            check_eq("after_rst_first", 32'(last_first), 32'd1);
            check_eq("after_rst_data", 32'(last_data), 32'h0ABCDE);
        end
        wait_drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
